cacheline_adaptor_p: RTL and testbench

CACHELINE_ADAPTOR_P -- requirements
Module: cacheline_adaptor_p

---
 rtl/cacheline_adaptor_p.sv | 152 +++++++++++++++
 tb/tb_cacheline_adaptor_p.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_adaptor_p.sv
`default_nettype none
// ============================================================================
//  Module      : cacheline_adaptor_p
//  Description : Bridges whole cache-line read/write requests onto a narrower
//                burst-oriented memory port. A line is moved as NUM_BURSTS
//                consecutive bursts, lowest slot first. One resp_o pulse
//                marks completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module cacheline_adaptor_p #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LINE_W-1:0]   line_i,
  output logic [LINE_W-1:0]   line_o,
  input  logic [ADDR_W-1:0]   address_i,
  input  logic                read_i,
  input  logic                write_i,
  output logic                resp_o,
  input  logic [BURST_W-1:0]  burst_i,
  output logic [BURST_W-1:0]  burst_o,
  output logic [ADDR_W-1:0]   address_o,
  output logic                read_o,
  output logic                write_o,
  input  logic                resp_i
);

  localparam int NUM_BURSTS = LINE_W / BURST_W;
  localparam int OFS_W      = $clog2(LINE_W / 8);
  localparam int CNT_W      = (NUM_BURSTS > 2) ? $clog2(NUM_BURSTS) : 1;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_BURSTS - 1);

  // Reject geometries that cannot be split into a power-of-two burst count.
  generate
    if ((LINE_W % BURST_W) != 0 || NUM_BURSTS < 2 ||
        (NUM_BURSTS & (NUM_BURSTS - 1)) != 0) begin : g_param_check
      $error("cacheline_adaptor_p: unsupported LINE_W/BURST_W combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                              state_q, state_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic [ADDR_W-1:0]                   addr_q, addr_d;
  // Line slots are packed so that slot k occupies bits [k*BURST_W +: BURST_W].
  logic [NUM_BURSTS-1:0][BURST_W-1:0]  wline_q, wline_d;
  logic [NUM_BURSTS-1:0][BURST_W-1:0]  rline_q, rline_d;

  // State, counter and data registers; reset aborts any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
    end
  end

  // Next-state logic: accept a request in IDLE (write has priority), then
  // step the burst counter on every accepted burst until the last slot.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    rline_d = rline_q;
    case (state_q)
      ST_IDLE: begin
        if (write_i) begin
          addr_d  = address_i;
          wline_d = line_i;
          cnt_d   = '0;
          state_d = ST_WR;
        end else if (read_i) begin
          addr_d  = address_i;
          cnt_d   = '0;
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        if (resp_i) begin
          rline_d[cnt_q] = burst_i;
          cnt_d          = cnt_q + 1'b1;
          if (cnt_q == LAST_SLOT) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_WR: begin
        if (resp_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_SLOT) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Memory-side outputs are decoded purely from the current state so that
  // nothing leaks onto the bus outside an active transfer.
  always_comb begin
    read_o    = 1'b0;
    write_o   = 1'b0;
    resp_o    = 1'b0;
    address_o = '0;
    burst_o   = '0;
    case (state_q)
      ST_RD: begin
        read_o    = 1'b1;
        address_o = {addr_q[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
      end
      ST_WR: begin
        write_o   = 1'b1;
        address_o = {addr_q[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
        burst_o   = wline_q[cnt_q];
      end
      ST_DONE: begin
        resp_o = 1'b1;
      end
      default: begin
        resp_o = 1'b0;
      end
    endcase
  end

  assign line_o = rline_q;

endmodule
`default_nettype wire

// File: tb/tb_cacheline_adaptor_p.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cacheline_adaptor_p
//  Description : Self-checking bench for cacheline_adaptor_p. A line-level
//                reference model predicts bus activity and assembled lines.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cacheline_adaptor_p;

  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int ADDR_W  = 32;
  localparam int NB      = LINE_W / BURST_W;
  localparam int OFS_W   = $clog2(LINE_W / 8);

  localparam int LINE2_W  = 512;
  localparam int BURST2_W = 128;
  localparam int NB2      = LINE2_W / BURST2_W;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [LINE_W-1:0]  line_i = '0;
  logic [LINE_W-1:0]  line_o;
  logic [ADDR_W-1:0]  address_i = '0;
  logic               read_i = 1'b0;
  logic               write_i = 1'b0;
  logic               resp_o;
  logic [BURST_W-1:0] burst_i = '0;
  logic [BURST_W-1:0] burst_o;
  logic [ADDR_W-1:0]  address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i = 1'b0;

  logic [LINE2_W-1:0]  line2_i = '0;
  logic [LINE2_W-1:0]  line2_o;
  logic [ADDR_W-1:0]   address2_i = '0;
  logic                read2_i = 1'b0;
  logic                write2_i = 1'b0;
  logic                resp2_o;
  logic [BURST2_W-1:0] burst2_i = '0;
  logic [BURST2_W-1:0] burst2_o;
  logic [ADDR_W-1:0]   address2_o;
  logic                read2_o;
  logic                write2_o;
  logic                resp2_i = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Line the model expects on line_o: last completed read, or 0 after reset.
  logic [LINE_W-1:0] last_rd_line = '0;

  always #5 clk = ~clk;

  cacheline_adaptor_p #(.LINE_W(LINE_W), .BURST_W(BURST_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  cacheline_adaptor_p #(.LINE_W(LINE2_W), .BURST_W(BURST2_W), .ADDR_W(ADDR_W)) dut2 (
    .clk(clk), .rst(rst), .line_i(line2_i), .line_o(line2_o),
    .address_i(address2_i), .read_i(read2_i), .write_i(write2_i), .resp_o(resp2_o),
    .burst_i(burst2_i), .burst_o(burst2_o), .address_o(address2_o),
    .read_o(read2_o), .write_o(write2_o), .resp_i(resp2_i)
  );

  task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int w = 0; w < LINE_W / 32; w++) l[w*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic check_quiet(input string tag);
    check_val({tag, "_read_o"},    read_o,    0);
    check_val({tag, "_write_o"},   write_o,   0);
    check_val({tag, "_resp_o"},    resp_o,    0);
    check_val({tag, "_address_o"}, address_o, 0);
    check_val({tag, "_burst_o"},   burst_o,   0);
  endtask

  // One full line transfer. Memory accepts slot k when resp_i is high; the
  // gap pattern (LSB first) or a random gap percentage decides each cycle.
  task automatic run_txn(input bit wr, input bit hold_rd, input logic [ADDR_W-1:0] a,
                         input logic [LINE_W-1:0] wl, input logic [LINE_W-1:0] rl,
                         input int gap_pct, input logic [15:0] pat, input int pat_len);
    int k, cyc, gaps, step;
    bit r;
    logic [ADDR_W-1:0] exp_a;
    exp_a = a;
    exp_a[OFS_W-1:0] = '0;
    write_i   = wr;
    read_i    = !wr || hold_rd;
    address_i = a;
    line_i    = wl;
    resp_i    = 1'($urandom_range(1, 0));
    burst_i   = {$urandom, $urandom};
    @(posedge clk); #1;
    cyc = 2;
    write_i   = 1'b0;
    read_i    = hold_rd;
    address_i = $urandom;
    line_i    = rand_line();
    k = 0; gaps = 0; step = 0;
    while (k < NB && step < 400) begin
      check_val("xfer_read_o",    read_o,    !wr);
      check_val("xfer_write_o",   write_o,   wr);
      check_val("xfer_address_o", address_o, exp_a);
      check_val("xfer_resp_o",    resp_o,    0);
      check_val("xfer_burst_o",   burst_o,   wr ? wl[k*BURST_W +: BURST_W] : '0);
      if (step < pat_len) r = pat[step];
      else                r = ($urandom_range(99, 0) >= gap_pct);
      resp_i  = r;
      burst_i = r ? rl[k*BURST_W +: BURST_W] : {$urandom, $urandom};
      @(posedge clk); #1;
      cyc++; step++;
      if (r) k++; else gaps++;
    end
    if (k < NB) check_val("xfer_timeout", k, NB);
    resp_i = 1'b0;
    check_val("done_resp_o",    resp_o,    1);
    check_val("done_read_o",    read_o,    0);
    check_val("done_write_o",   write_o,   0);
    check_val("done_address_o", address_o, 0);
    check_val("done_latency",   cyc,       NB + 2 + gaps);
    if (!wr) last_rd_line = rl;
    check_val("done_line_o", line_o, last_rd_line);
    @(posedge clk); #1;
    check_val("idle_resp_o", resp_o, 0);
    check_val("idle_read_o", read_o, 0);
    check_val("idle_line_o", line_o, last_rd_line);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [LINE_W-1:0]  l, l2;
    logic [LINE2_W-1:0] rl2;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_quiet("rst");
    check_val("rst_line_o", line_o, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_quiet("post_rst");

    // Directed read at 0x1234_5678, bursts A0..A3, resp_i never gapped
    l = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
    run_txn(1'b0, 1'b0, 32'h1234_5678, '0, l, 0, 16'h0, 0);
    check_val("rd_line_order", line_o, {64'hA3, 64'hA2, 64'hA1, 64'hA0});

    // Directed write at 0x40 with resp_i pattern 1,0,1,1,0,1
    l = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
    run_txn(1'b1, 1'b0, 32'h0000_0040, l, '0, 0, 16'b101101, 6);

    // Both requests together: write first, read held through DONE follows
    run_txn(1'b1, 1'b1, 32'h0000_1000, rand_line(), '0, 30, 16'h0, 0);
    run_txn(1'b0, 1'b0, 32'h0000_2000, '0, rand_line(), 30, 16'h0, 0);

    // Reset after two read bursts aborts cleanly
    l = rand_line();
    read_i = 1'b1; address_i = 32'h0000_3000;
    @(posedge clk); #1;
    read_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      resp_i = 1'b1; burst_i = l[k*BURST_W +: BURST_W];
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check_quiet("abort");
    check_val("abort_line_o", line_o, 0);
    rst = 1'b0; resp_i = 1'b0;
    last_rd_line = '0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check_val("abort_no_resp", resp_o, 0);
    end
    run_txn(1'b0, 1'b0, 32'h0000_3000, '0, rand_line(), 0, 16'h0, 0);

    // Stray resp_i in IDLE must not advance the burst counter
    resp_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      burst_i = {$urandom, $urandom};
      @(posedge clk); #1;
      check_val("stray_resp_o", resp_o, 0);
      check_val("stray_read_o", read_o, 0);
    end
    resp_i = 1'b0;
    run_txn(1'b0, 1'b0, 32'h0000_4444, '0, rand_line(), 0, 16'h0, 0);

    // Randomized mix of reads and writes with random gaps
    for (int t = 0; t < 24; t++) begin
      l  = rand_line();
      l2 = rand_line();
      run_txn(1'($urandom_range(1, 0)), 1'b0, $urandom, l, l2,
              $urandom_range(60, 0), 16'h0, 0);
    end

    // Wide geometry: 512-bit line over 128-bit bursts, 6 offset bits
    for (int k = 0; k < NB2; k++)
      for (int w = 0; w < 4; w++) rl2[k*BURST2_W + w*32 +: 32] = $urandom;
    read2_i = 1'b1; address2_i = 32'hDEAD_BEFF;
    @(posedge clk); #1;
    read2_i = 1'b0;
    for (int k = 0; k < NB2; k++) begin
      check_val("w2_read_o",    read2_o,    1);
      check_val("w2_address_o", address2_o, 32'hDEAD_BEC0);
      check_val("w2_resp_o",    resp2_o,    0);
      resp2_i = 1'b1; burst2_i = rl2[k*BURST2_W +: BURST2_W];
      @(posedge clk); #1;
    end
    resp2_i = 1'b0;
    check_val("w2_done_resp_o", resp2_o, 1);
    check_val("w2_line_o",      line2_o, rl2);
    @(posedge clk); #1;
    check_val("w2_idle_resp_o", resp2_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
